// File: rtl/pwm_array_pkg.sv
// pwm_array_pkg: mode constants, duty width helper and sample-to-duty conversion for pwm_array.
package pwm_array_pkg;
    localparam int EDGE   = 0;
    localparam int CENTER = 1;

    function automatic int duty_width(input int cw);
        return cw + 1;
    endfunction

    function automatic logic [31:0] adjust(input logic [31:0] sample, input int iw, input int offset);
        return (sample + 32'(offset)) & ((32'd1 << iw) - 32'd1);
    endfunction

    function automatic logic [31:0] base_duty(input logic [31:0] sample, input int iw, input int cw, input int offset);
        return adjust(sample, iw, offset) >> (iw - cw);
    endfunction

    function automatic logic [31:0] residual(input logic [31:0] sample, input int iw, input int cw, input int offset);
        return adjust(sample, iw, offset) & ((32'd1 << (iw - cw)) - 32'd1);
    endfunction
endpackage

// File: rtl/pwm_array_channel.sv
// pwm_channel: one PWM output holding its active duty and registered compare.
// PWM_ARRAY_DITHER_EN adds a per-channel residual accumulator whose carry stretches the duty by one.
module pwm_channel
    import pwm_array_pkg::*;
#(
    parameter int INPUT_WIDTH   = 12,
    parameter int COUNTER_WIDTH = 10,
    parameter int OFFSET        = 512
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable_i,
    input  logic                     tick_i,
    input  logic                     load_i,
    input  logic [INPUT_WIDTH-1:0]   sample_i,
    input  logic [COUNTER_WIDTH-1:0] count_i,
    output logic                     pwm_o
);
    localparam int CW = COUNTER_WIDTH;
    localparam int R  = INPUT_WIDTH - COUNTER_WIDTH;
    localparam int DW = duty_width(CW);
`ifdef PWM_ARRAY_DITHER_EN
    localparam bit DITHER = R > 0;
`else
    localparam bit DITHER = 1'b0;
`endif
    logic [CW-1:0] base_new;
    logic [DW-1:0] duty_q, duty_d;
    logic          pwm_q;

    assign base_new = CW'(base_duty(32'(sample_i), INPUT_WIDTH, CW, OFFSET));

    if (DITHER) begin : g_dither
        logic [CW-1:0] base_q;
        logic [R-1:0]  res_q, acc_q, res_new, res_cur;
        logic [R:0]    sum;
        assign res_new = R'(residual(32'(sample_i), INPUT_WIDTH, CW, OFFSET));
        assign res_cur = load_i ? res_new : res_q;
        assign sum     = {1'b0, acc_q} + {1'b0, res_cur};
        // base is at most 2^CW-1, so adding the carry saturates at full-on by construction
        assign duty_d  = tick_i ? {1'b0, (load_i ? base_new : base_q)} + DW'(sum[R]) : duty_q;
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                base_q <= '0;
                res_q  <= '0;
                acc_q  <= '0;
            end else if (tick_i) begin
                if (load_i) begin
                    base_q <= base_new;
                    res_q  <= res_new;
                end
                acc_q <= sum[R-1:0];
            end
    end else begin : g_plain
        assign duty_d = (tick_i && load_i) ? {1'b0, base_new} : duty_q;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            pwm_q  <= enable_i && ({1'b0, count_i} < duty_q);
        end

    assign pwm_o = pwm_q;
endmodule

// File: rtl/pwm_array.sv
// pwm_array: multi-channel double-buffered PWM with shared edge/centre-aligned counter.
// Define PWM_ARRAY_DITHER_EN to enable sub-LSB dither in every channel.
module pwm_array
    import pwm_array_pkg::*;
#(
    parameter int CHANNELS       = 2,
    parameter int INPUT_WIDTH    = 12,
    parameter int COUNTER_WIDTH  = 10,
    parameter int OFFSET         = 512,
    parameter int CENTER_ALIGNED = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic [CHANNELS*INPUT_WIDTH-1:0] data_in,
    input  logic                            data_valid,
    output logic                            data_ready,
    output logic [CHANNELS-1:0]             pwm_out,
    output logic                            period_start,
    output logic                            underrun
);
    localparam int CW = COUNTER_WIDTH;
    localparam logic [CW-1:0] CMAX = '1;
    logic [CW-1:0]                   count_q, count_d;
    logic                            down_q, down_d;
    logic                            full_q, full_d;
    logic [CHANNELS*INPUT_WIDTH-1:0] shadow_q;
    logic                            bnd_q, urn_q, start_q, under_q;
    logic                            boundary, load, xfer;

    assign load       = data_valid && !full_q;
    assign boundary   = enable && ((CENTER_ALIGNED == CENTER) ? (down_q && count_q == CW'(1)) : (count_q == CMAX));
    assign xfer       = boundary && full_q;
    assign full_d     = load ? 1'b1 : (xfer ? 1'b0 : full_q);
    assign data_ready = !full_q;

    always_comb begin
        count_d = '0;
        down_d  = 1'b0;
        if (enable && CENTER_ALIGNED == CENTER) begin
            count_d = (down_q || count_q == CMAX) ? count_q - 1'b1 : count_q + 1'b1;
            down_d  = down_q ? (count_q != CW'(1)) : (count_q == CMAX);
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    // Pulses go through two stages so they line up with the first registered output of a period
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            count_q  <= '0;
            down_q   <= 1'b0;
            full_q   <= 1'b0;
            shadow_q <= '0;
            bnd_q    <= 1'b0;
            urn_q    <= 1'b0;
            start_q  <= 1'b0;
            under_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            down_q  <= down_d;
            full_q  <= full_d;
            if (load) shadow_q <= data_in;
            bnd_q   <= boundary;
            urn_q   <= boundary && !full_q;
            start_q <= bnd_q && enable;
            under_q <= urn_q && enable;
        end

    assign period_start = start_q;
    assign underrun     = under_q;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        pwm_channel #(
            .INPUT_WIDTH  (INPUT_WIDTH),
            .COUNTER_WIDTH(COUNTER_WIDTH),
            .OFFSET       (OFFSET)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .enable_i(enable),
            .tick_i  (boundary),
            .load_i  (xfer),
            .sample_i(shadow_q[k*INPUT_WIDTH +: INPUT_WIDTH]),
            .count_i (count_q),
            .pwm_o   (pwm_out[k])
        );
    end
endmodule

// File: doc/pwm_array.md
# pwm_array

Multi-channel, double-buffered PWM generator; parametrised successor to the single-channel audio PWM. It drives `CHANNELS` outputs from one shared period counter and accepts a new sample word for all channels through a valid/ready handshake. New duties take effect only at period boundaries, in edge- or centre-aligned mode, with optional sub-LSB dither. It sits between the demodulator/decimator output and the DAC pins.

## Interface
- `CHANNELS`, 2: number of PWM outputs.
- `INPUT_WIDTH`, 12: sample width per channel; must be ≥ `COUNTER_WIDTH`.
- `COUNTER_WIDTH`, 10: period counter width.
- `OFFSET`, 512: added to each sample, modulo 2^`INPUT_WIDTH`.
- `CENTER_ALIGNED`, 0: 0 = edge-aligned sawtooth counter; 1 = up/down triangle counter.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `enable`  in  1  run counter and outputs.
- `data_in`  in  `CHANNELS*INPUT_WIDTH`  channel k in bits [k*IW +: IW].
- `data_valid`  in  1  `data_in` holds a sample word.
- `data_ready`  out  1  shadow buffer empty.
- `pwm_out`  out  `CHANNELS`  PWM outputs, registered.
- `period_start`  out  1  one-cycle pulse at the first cycle of each period.
- `underrun`  out  1  one-cycle pulse when a boundary finds the shadow empty.

## Operation
- **Adjusted value.** adj = (sample + `OFFSET`) mod 2^IW. The base duty is the top `COUNTER_WIDTH` bits of adj. The residual is the low R = IW−CW bits.
- **Active duty.** Each channel's active duty is CW+1 bits wide, so a full-on duty of 2^CW is representable.
- **Shadow buffer.**
  - One shadow register holds a full sample word for all channels.
  - A load happens when `data_valid && data_ready`.
  - `data_ready` = shadow empty.
- **Edge-aligned counter.** Counts 0 → 2^CW−1 and wraps. The boundary is the cycle where count = 2^CW−1.
- **Centre-aligned counter.**
  - Counts up 0 → 2^CW−1, then down to 1.
  - Period is 2^(CW+1)−2 cycles.
  - The boundary is the cycle where count = 1 on the down-ramp.
- **Boundary with the shadow full.** Shadow → active duties; shadow marked empty.
- **Boundary with the shadow empty.** Active duties are held and `underrun` pulses.
- **Load in the same cycle as a boundary.** The boundary sees the shadow as empty: the duties are held and `underrun` pulses. The incoming word lands in the shadow.
- **Compare.** `pwm_out[k]` is 1 when count < active duty[k].
  - Duty 0 gives constant 0.
  - Duty 2^CW gives constant 1.
- **Enable low.**
  - Counter is forced to 0 and `pwm_out` to 0.
  - No boundaries occur and `period_start`/`underrun` stay 0.
  - The shadow still accepts a word.
  - Active duties are held.
  - When `enable` rises, counting resumes from 0.

## Timing
- **Reset values.** count 0, active duties 0, shadow empty, `data_ready` 1, `pwm_out` 0, `period_start` 0, `underrun` 0.
- **Reset mid-operation.** Asynchronously clears all of the above; any held shadow word is lost.
- **Output latency.** `pwm_out` is the compare of the previous cycle's count, so it lags count by one cycle.
- **Boundary update.** The transfer happens on the same edge as count reaches its first value of the period. The first `pwm_out` of the new period therefore uses the new duty.
- **Pulse timing.** `period_start` and `underrun` are registered. They assert in the cycle whose `pwm_out` is the first of the new period.
- **Handshake.**
  - `data_ready` falls the cycle after an accepted load.
  - It rises the cycle after the boundary transfer.
  - Peak throughput is one word per period.

## Configuration
- **Macro:** `PWM_ARRAY_DITHER_EN`.
- **Defined:**
  - Each channel keeps an R-bit residual accumulator.
  - At every boundary: acc += residual of the current sample.
  - The carry adds 1 to that period's duty, capped at 2^CW.
  - Accumulators reset to 0.
  - A fresh transfer does not clear the accumulator.
- **Undefined:** the residual is discarded; duty = base duty. No accumulator registers exist.
- **R = 0:** behaviour is identical with or without the macro.

## Structure
- **Package `pwm_array_pkg`:**
  - duty type width (CW+1) helper;
  - mode constants EDGE/CENTER;
  - function computing base duty and residual from a sample and `OFFSET`.
- **Sub-module `pwm_channel`:** one per channel, in a generate loop. Holds the active duty, the dither accumulator and the compare/output register.
- **Top level:** counter, boundary detect, shadow buffer, handshake and pulse outputs.

## Test plan
All scenarios use IW=6, CW=4, OFFSET=0, edge-aligned unless stated.
- **Reset and enable.** Reset, then `enable`=1 with no data → `pwm_out`=0 throughout. `underrun` pulses every 16 cycles. `period_start` is aligned with it.
- **Basic duty.** Load ch0=0x20, ch1=0x3F before the first boundary.
  - Next period: ch0 high 8 of 16 cycles, ch1 high 15 of 16.
  - `data_ready` is low until the transfer, then high.
- **Load on boundary.** `data_valid` coincides with the count=15 cycle → `underrun` pulses. Old duty is kept for one more period. The new duty applies in the period after.
- **Centre-aligned.** `CENTER_ALIGNED`=1, ch0=0x20 → period of 30 cycles; `pwm_out` high 15 cycles, centred on count 0.
- **Dither.** With `PWM_ARRAY_DITHER_EN` defined, ch0=0x21 reloaded every period → high times 8,8,8,9 repeating. Without the macro → 8 every period.
- **Reset mid-period.** Deassert `rst_n` at count 7 with the shadow full → outputs 0 immediately, `data_ready`=1, shadow word discarded.
